chest_equalizer_sink: RTL

- Downstream consumer of the interpolated channel estimates h_eqlz_1 and h_eqlz_2 (real/imag, two subcarriers per beat).
- Buffers the incoming estimate pairs and pairs each one with the matching received data-RE pair.
- Computes the phase-equalized product z = y * conj(h) per lane in a 2-stage pipeline.
- Delivers the results to the demapper over a valid/ready interface, with subcarrier indexing per NB-IoT symbol.

---
 rtl/chest_equalizer_sink.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/chest_equalizer_sink.sv
// Equalizer sink: buffers channel-estimate pairs, multiplies each received RE pair by
// conj(h) in a two-stage pipeline and hands the rounded, saturated result to the demapper.
module chest_equalizer_sink #(
    parameter int H_WIDTH   = 17,
    parameter int Y_WIDTH   = 16,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15,
    parameter int H_DEPTH   = 4,
    parameter int N_SC      = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        h_valid,
    input  logic signed [H_WIDTH-1:0]   h_eqlz_1_r,
    input  logic signed [H_WIDTH-1:0]   h_eqlz_1_i,
    input  logic signed [H_WIDTH-1:0]   h_eqlz_2_r,
    input  logic signed [H_WIDTH-1:0]   h_eqlz_2_i,
    input  logic                        y_valid,
    output logic                        y_ready,
    input  logic signed [Y_WIDTH-1:0]   y1_r,
    input  logic signed [Y_WIDTH-1:0]   y1_i,
    input  logic signed [Y_WIDTH-1:0]   y2_r,
    input  logic signed [Y_WIDTH-1:0]   y2_i,
    output logic                        z_valid,
    input  logic                        z_ready,
    output logic signed [OUT_WIDTH-1:0] z1_r,
    output logic signed [OUT_WIDTH-1:0] z1_i,
    output logic signed [OUT_WIDTH-1:0] z2_r,
    output logic signed [OUT_WIDTH-1:0] z2_i,
    output logic [3:0]                  sc_idx,
    output logic                        last_sc,
    output logic                        h_ovf
);

    localparam int PW = Y_WIDTH + H_WIDTH;
    localparam int SW = PW + 1;
    localparam int AW = $clog2(H_DEPTH);
    localparam int FW = 4 * H_WIDTH;
    localparam logic signed [SW-1:0] RND  = SW'(1) << (SHIFT - 1);
    localparam logic signed [SW-1:0] OMAX = (SW'(1) << (OUT_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] OMIN = -(SW'(1) << (OUT_WIDTH - 1));
    localparam logic [3:0]           SC_LAST = 4'(N_SC - 2);

    logic [FW-1:0]  fifo_mem [H_DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    count_reg, count_next;
    logic [FW-1:0]  fifo_head;
    logic           fifo_full, fifo_not_empty;
    logic           adv, accept, push;
    logic [3:0]     sc_reg;
    logic           s1_valid_reg, s2_valid_reg;
    logic [3:0]     s1_sc_reg, s2_sc_reg;
    logic           s1_last_reg, s2_last_reg;
    logic           h_ovf_reg;

    logic signed [Y_WIDTH-1:0]   lane_y_r [2];
    logic signed [Y_WIDTH-1:0]   lane_y_i [2];
    logic signed [H_WIDTH-1:0]   lane_h_r [2];
    logic signed [H_WIDTH-1:0]   lane_h_i [2];
    logic signed [OUT_WIDTH-1:0] lane_z_r [2];
    logic signed [OUT_WIDTH-1:0] lane_z_i [2];

    assign fifo_full      = (count_reg == (AW+1)'(H_DEPTH));
    assign fifo_not_empty = (count_reg != '0);
    assign adv            = !s2_valid_reg || z_ready;
    assign y_ready        = fifo_not_empty && adv;
    assign accept         = y_valid && y_ready;
    // A full FIFO still takes the new pair when the head leaves in the same cycle.
    assign push           = h_valid && (!fifo_full || accept);
    assign count_next     = count_reg + (AW+1)'(push) - (AW+1)'(accept);
    assign fifo_head      = fifo_mem[rd_ptr_reg];

    assign lane_y_r[0] = y1_r;
    assign lane_y_i[0] = y1_i;
    assign lane_y_r[1] = y2_r;
    assign lane_y_i[1] = y2_i;
    assign lane_h_r[0] = fifo_head[4*H_WIDTH-1 -: H_WIDTH];
    assign lane_h_i[0] = fifo_head[3*H_WIDTH-1 -: H_WIDTH];
    assign lane_h_r[1] = fifo_head[2*H_WIDTH-1 -: H_WIDTH];
    assign lane_h_i[1] = fifo_head[H_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            fifo_mem[wr_ptr_reg] <= {h_eqlz_1_r, h_eqlz_1_i, h_eqlz_2_r, h_eqlz_2_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            sc_reg       <= '0;
            h_ovf_reg    <= 1'b0;
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s1_sc_reg    <= '0;
            s2_sc_reg    <= '0;
            s1_last_reg  <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            sc_reg       <= '0;
            h_ovf_reg    <= 1'b0;
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s1_sc_reg    <= '0;
            s2_sc_reg    <= '0;
            s1_last_reg  <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else begin
            if (push)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (accept) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            if (h_valid && !push) h_ovf_reg <= 1'b1;
            if (accept) sc_reg <= (sc_reg == SC_LAST) ? 4'd0 : sc_reg + 4'd2;
            if (adv) begin
                s1_valid_reg <= accept;
                s2_valid_reg <= s1_valid_reg;
                if (accept) begin
                    s1_sc_reg   <= sc_reg;
                    s1_last_reg <= (sc_reg == SC_LAST);
                end
                if (s1_valid_reg) begin
                    s2_sc_reg   <= s1_sc_reg;
                    s2_last_reg <= s1_last_reg;
                end
            end
        end
    end

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > OMAX)      return OMAX[OUT_WIDTH-1:0];
        else if (v < OMIN) return OMIN[OUT_WIDTH-1:0];
        else               return v[OUT_WIDTH-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [PW-1:0]        p_rr_reg, p_ii_reg, p_ir_reg, p_ri_reg;
            logic signed [SW-1:0]        re_sum, im_sum, re_rnd, im_rnd;
            logic signed [OUT_WIDTH-1:0] z_r_reg, z_i_reg;

            assign re_sum = SW'(p_rr_reg) + SW'(p_ii_reg);
            assign im_sum = SW'(p_ir_reg) - SW'(p_ri_reg);
            assign re_rnd = (re_sum + RND) >>> SHIFT;
            assign im_rnd = (im_sum + RND) >>> SHIFT;

            // Data registers only load with a real pair so idle outputs stay put.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p_rr_reg <= '0;
                    p_ii_reg <= '0;
                    p_ir_reg <= '0;
                    p_ri_reg <= '0;
                    z_r_reg  <= '0;
                    z_i_reg  <= '0;
                end else if (clear) begin
                    p_rr_reg <= '0;
                    p_ii_reg <= '0;
                    p_ir_reg <= '0;
                    p_ri_reg <= '0;
                    z_r_reg  <= '0;
                    z_i_reg  <= '0;
                end else if (adv) begin
                    if (accept) begin
                        p_rr_reg <= PW'(lane_y_r[gi]) * PW'(lane_h_r[gi]);
                        p_ii_reg <= PW'(lane_y_i[gi]) * PW'(lane_h_i[gi]);
                        p_ir_reg <= PW'(lane_y_i[gi]) * PW'(lane_h_r[gi]);
                        p_ri_reg <= PW'(lane_y_r[gi]) * PW'(lane_h_i[gi]);
                    end
                    if (s1_valid_reg) begin
                        z_r_reg <= saturate(re_rnd);
                        z_i_reg <= saturate(im_rnd);
                    end
                end
            end

            assign lane_z_r[gi] = z_r_reg;
            assign lane_z_i[gi] = z_i_reg;
        end
    endgenerate

    assign z_valid = s2_valid_reg;
    assign z1_r    = lane_z_r[0];
    assign z1_i    = lane_z_i[0];
    assign z2_r    = lane_z_r[1];
    assign z2_i    = lane_z_i[1];
    assign sc_idx  = s2_sc_reg;
    assign last_sc = s2_last_reg;
    assign h_ovf   = h_ovf_reg;

endmodule
